// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and constants for the byte-enable simple dual-port RAM
//
// Purpose : clear-sweep FSM state encoding and the legal read-latency range,
//           shared by ram_clear_fsm and ram_sdp_be.
// Ports   : none (package).

package ram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Folds any requested latency onto the supported pair (1 or 2).
  function automatic int rd_lat_eff(input int lat);
    return (lat <= RD_LAT_MIN) ? RD_LAT_MIN : RD_LAT_MAX;
  endfunction

endpackage

// File: rtl/ram_clear_fsm.sv
// rtl/ram_clear_fsm.sv - zero-fill sweep controller for the byte-enable RAM
//
// Purpose : two-state IDLE/CLEAR machine with an AW-bit sweep counter that
//           walks addresses 0..WORDS-1, one word per cycle.
// Ports   : clk      - rising-edge clock
//           rst      - asynchronous active-high reset
//           clr      - single-cycle request to start a sweep (ignored in CLEAR)
//           busy     - high exactly while in CLEAR
//           clr_addr - address being zeroed this cycle
//           clr_we   - zero-write strobe for clr_addr

module ram_clear_fsm
  import ram_pkg::*;
#(
  parameter int WORDS      = 256,
  parameter int INIT_CLEAR = 1,
  parameter int AW         = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic          busy,
  output logic [AW-1:0] clr_addr,
  output logic          clr_we
);

  localparam logic [AW-1:0] LAST = AW'(WORDS - 1);

  clr_state_t    state, state_n;
  logic [AW-1:0] cnt, cnt_n;
  // Set by reset so that the first edge after release launches the
  // power-up sweep while busy still reads 0 during reset itself.
  logic          init_pend, init_pend_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      init_pend <= (INIT_CLEAR != 0);
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      init_pend <= init_pend_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    init_pend_n = init_pend;
    case (state)
      IDLE: begin
        if (clr || init_pend) begin
          state_n     = CLEAR;
          cnt_n       = '0;
          init_pend_n = 1'b0;
        end
      end
      CLEAR: begin
        if (cnt == LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + AW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy     = (state == CLEAR);
  assign clr_we   = (state == CLEAR);
  assign clr_addr = cnt;

endmodule

// File: rtl/ram_sdp_be.sv
// rtl/ram_sdp_be.sv - simple dual-port RAM with byte enables, pipelined reads and clear sweep
//
// Purpose : one write port with per-byte lane enables, one read port with a
//           latency of 1 or 2 cycles (fully pipelined), and a zero-fill sweep
//           that blocks both ports while busy.
// Macro   : RAM_SDP_FWD_EN - when defined, a same-address read and write in one
//           cycle returns the new bytes in enabled lanes (write-first);
//           otherwise the old word is returned (read-first).
// Ports   : clk, rst (async active-high)
//           wr_en, wr_addr, wr_be, wr_data - write request
//           rd_en, rd_addr                  - read request
//           rd_valid, rd_data               - read response (rd_data holds when idle)
//           clr                             - start zero-fill sweep
//           busy                            - sweep in progress

module ram_sdp_be
  import ram_pkg::*;
#(
  parameter  int DW         = 32,
  parameter  int WORDS      = 256,
  parameter  int RD_LAT     = 1,
  parameter  int INIT_CLEAR = 1,
  localparam int AW         = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW/8-1:0] wr_be,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  input  logic          clr,
  output logic          busy
);

  localparam int NB  = DW / 8;
  localparam int LAT = rd_lat_eff(RD_LAT);

  logic [DW-1:0] mem [WORDS];
  logic [AW-1:0] clr_addr;
  logic          clr_we;
  logic          wr_acc, rd_acc;
  logic [DW-1:0] rd_word;

  ram_clear_fsm #(
    .WORDS      (WORDS),
    .INIT_CLEAR (INIT_CLEAR),
    .AW         (AW)
  ) u_clear (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .busy     (busy),
    .clr_addr (clr_addr),
    .clr_we   (clr_we)
  );

  assign wr_acc = wr_en & ~busy;
  assign rd_acc = rd_en & ~busy;

  // Array is deliberately not reset; only the sweep zeroes it.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_word = mem[rd_addr];
`ifdef RAM_SDP_FWD_EN
    if (wr_acc && (wr_addr == rd_addr)) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
      end
    end
`endif
  end

  // Data registers only load alongside their valid so rd_data holds between reads.
  if (LAT == 2) begin : g_lat2
    logic          s1_v;
    logic [DW-1:0] s1_d;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_v     <= 1'b0;
        s1_d     <= '0;
        rd_valid <= 1'b0;
        rd_data  <= '0;
      end else begin
        s1_v     <= rd_acc;
        if (rd_acc) s1_d <= rd_word;
        rd_valid <= s1_v;
        if (s1_v) rd_data <= s1_d;
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_valid <= 1'b0;
        rd_data  <= '0;
      end else begin
        rd_valid <= rd_acc;
        if (rd_acc) rd_data <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_ram_sdp_be.sv
// tb/tb_ram_sdp_be.sv - scoreboard bench for ram_sdp_be, latency 1 and 2 instances driven in parallel

module tb_ram_sdp_be;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en, clr;
  logic [3:0]  wr_addr, wr_be, rd_addr;
  logic [31:0] wr_data;
  logic        rd_valid1, busy1, rd_valid2, busy2;
  logic [31:0] rd_data1, rd_data2;

  int n_checks = 0;
  int n_fail   = 0;
  int edges    = 0;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t        q1[$], q2[$];
  exp_t        e1, e2;
  logic [31:0] last1, last2;

`ifdef RAM_SDP_FWD_EN
  localparam logic [31:0] COLL7 = 32'hCAFEF00D;
  localparam logic [31:0] COLL3 = 32'hDEAD5678;
`else
  localparam logic [31:0] COLL7 = 32'h00000000;
  localparam logic [31:0] COLL3 = 32'hDEADBEEF;
`endif

  ram_sdp_be #(.DW(32), .WORDS(16), .RD_LAT(1), .INIT_CLEAR(1)) u_dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid1),
    .rd_data(rd_data1), .clr(clr), .busy(busy1)
  );

  ram_sdp_be #(.DW(32), .WORDS(16), .RD_LAT(2), .INIT_CLEAR(1)) u_dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid2),
    .rd_data(rd_data2), .clr(clr), .busy(busy2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor for the latency-1 instance.
  always @(negedge clk) begin
    if (rst) begin
      last1 = '0;
    end else begin
      if (q1.size() > 0 && edges > q1[0].due) begin
        n_checks++; n_fail++;
        $display("FAIL rd1_missing: no rd_valid at edge %0d, required by edge %0d", edges, q1[0].due);
        void'(q1.pop_front());
      end
      if (rd_valid1) begin
        if (q1.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rd1_unexpected: rd_valid=1 required 0 (data 0x%08h)", rd_data1);
        end else begin
          e1 = q1.pop_front();
          chk("rd1_latency", edges, e1.due);
          chk("rd1_data", rd_data1, e1.data);
        end
        last1 = rd_data1;
      end else begin
        chk("rd1_hold", rd_data1, last1);
      end
    end
  end

  // Monitor for the latency-2 instance.
  always @(negedge clk) begin
    if (rst) begin
      last2 = '0;
    end else begin
      if (q2.size() > 0 && edges > q2[0].due) begin
        n_checks++; n_fail++;
        $display("FAIL rd2_missing: no rd_valid at edge %0d, required by edge %0d", edges, q2[0].due);
        void'(q2.pop_front());
      end
      if (rd_valid2) begin
        if (q2.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rd2_unexpected: rd_valid=1 required 0 (data 0x%08h)", rd_data2);
        end else begin
          e2 = q2.pop_front();
          chk("rd2_latency", edges, e2.due);
          chk("rd2_data", rd_data2, e2.data);
        end
        last2 = rd_data2;
      end else begin
        chk("rd2_hold", rd_data2, last2);
      end
    end
  end

  // One cycle of stimulus; a read pushes its expected word with the edge at
  // which each instance must present it.
  task automatic op(input logic we, input logic [3:0] wa, input logic [3:0] be,
                    input logic [31:0] wd, input logic re, input logic [3:0] ra,
                    input logic [31:0] rexp, input logic c);
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
    rd_en = re; rd_addr = ra; clr = c;
    if (re) begin
      q1.push_back('{edges + 1, rexp});
      q2.push_back('{edges + 2, rexp});
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
    op(1'b1, a, be, d, 1'b0, 4'd0, 32'd0, 1'b0);
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp);
    op(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, a, exp, 1'b0);
  endtask

  // Counts busy cycles of both instances; optionally pokes all requests mid-sweep.
  task automatic measure_busy(input string nm, input bit inject);
    int c1, c2;
    c1 = 0; c2 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy1) c1++;
      if (busy2) c2++;
      wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
      if (inject && i == 5) begin
        wr_en = 1'b1; wr_addr = 4'd2; wr_be = 4'hF; wr_data = 32'hFFFFFFFF;
        rd_en = 1'b1; rd_addr = 4'd3; clr = 1'b1;
      end
      if (!busy1 && !busy2) break;
    end
    chk({nm, "_busy_cycles1"}, c1, 16);
    chk({nm, "_busy_cycles2"}, c2, 16);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
    wr_addr = '0; wr_be = '0; wr_data = '0; rd_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy1", busy1, 0);
    chk("rst_busy2", busy2, 0);
    chk("rst_rd_valid1", rd_valid1, 0);
    chk("rst_rd_valid2", rd_valid2, 0);
    chk("rst_rd_data1", rd_data1, 0);
    chk("rst_rd_data2", rd_data2, 0);

    rst = 1'b0;
    @(negedge clk);
    chk("init_busy_edge1_1", busy1, 1);
    chk("init_busy_edge1_2", busy2, 1);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midsweep_rst_busy1", busy1, 0);
    chk("midsweep_rst_busy2", busy2, 0);
    repeat (2) @(negedge clk);
    chk("rst_held_busy1", busy1, 0);
    chk("rst_held_busy2", busy2, 0);
    rst = 1'b0;
    measure_busy("restart", 1'b0);

    wr(4'd3, 4'hF, 32'hDEADBEEF);
    rd(4'd3, 32'hDEADBEEF);
    wr(4'd5, 4'hF, 32'h11223344);
    wr(4'd5, 4'h5, 32'hAABBCCDD);
    rd(4'd5, 32'h11BB33DD);
    wr(4'd5, 4'h0, 32'hFFFFFFFF);
    rd(4'd5, 32'h11BB33DD);
    wr(4'd6, 4'hA, 32'h12345678);
    rd(4'd6, 32'h12005600);

    op(1'b1, 4'd7, 4'hF, 32'hCAFEF00D, 1'b1, 4'd7, COLL7, 1'b0);
    rd(4'd7, 32'hCAFEF00D);
    op(1'b1, 4'd3, 4'h3, 32'h12345678, 1'b1, 4'd3, COLL3, 1'b0);
    rd(4'd3, 32'hDEAD5678);

    wr(4'd0, 4'hF, 32'hA0A0A0A0);
    wr(4'd1, 4'hF, 32'hA1A1A1A1);
    wr(4'd2, 4'hF, 32'hA2A2A2A2);
    rd(4'd0, 32'hA0A0A0A0);
    rd(4'd1, 32'hA1A1A1A1);
    rd(4'd2, 32'hA2A2A2A2);

    for (int i = 0; i < 16; i++) wr(4'(i), 4'hF, 32'h10000000 | 32'(i));
    // clr together with a write (lands, then gets swept) and a read (returns pre-clear data).
    op(1'b1, 4'd4, 4'hF, 32'h44444444, 1'b1, 4'd15, 32'h1000000F, 1'b1);
    measure_busy("clr", 1'b1);
    for (int i = 0; i < 16; i++) rd(4'(i), 32'h00000000);

    repeat (4) op(1'b0, 4'd0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
